// File: rtl/bcd_scan_driver_pkg.sv
// Shared definitions for the multiplexed BCD display feeder: blank code,
// converter FSM states and the clamp limit for a given digit count.
package bcd_scan_driver_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Largest value representable in the given number of decimal digits (all 9s).
  function automatic int unsigned clamp_max(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bcd_scan_driver_if.sv
// Upstream handshake plus display-side signals of the BCD scan driver.
interface bcd_scan_driver_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  in_bin;
  logic              blank_lz;
  logic              conv_done;
  logic [3:0]        bcd;
  logic [DIGITS-1:0] an;

  modport master (
    output in_valid,
    output in_bin,
    output blank_lz,
    input  in_ready,
    input  conv_done,
    input  bcd,
    input  an
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    input  blank_lz,
    output in_ready,
    output conv_done,
    output bcd,
    output an
  );

endinterface

// File: rtl/bcd_scan_driver_bin2bcd_dd.sv
// Sequential double-dabble converter: one bit per cycle for BIN_W cycles,
// clamping out-of-range inputs to all 9s at accept time.
module bin2bcd_dd
  import bcd_scan_driver_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int          SR_W    = BIN_W + 4*DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = clamp_max(DIGITS);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              last;
  logic [BIN_W-1:0]  bin_clamped;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CONV;
          cnt_nxt   = '0;
        end
      end
      CONV: begin
        if (cnt == CNT_W'(BIN_W - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bin_clamped = (32'(bin) > MAX_VAL) ? BIN_W'(MAX_VAL) : bin;

  // Add-3 correction on every nibble before the shift, so the shifted nibble stays decimal.
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Datapath register: contents are only meaningful while CONV is active.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      sr <= {{(4*DIGITS){1'b0}}, bin_clamped};
    end else if (state == CONV) begin
      sr <= sr_shift;
    end
  end

  assign busy    = (state == CONV);
  assign done    = last;
  assign bcd_out = sr_shift[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/bcd_scan_driver.sv
// Display feeder: accepts a binary value, converts it to BCD and scans the
// committed digits onto one bcd bus with a one-hot active-high digit enable.
module bcd_scan_driver
  import bcd_scan_driver_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_scan_driver_if.slave   bus
);

  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  busy;
  logic                  accept;
  logic                  commit;
  logic [4*DIGITS-1:0]   conv_bcd;
  logic [4*DIGITS-1:0]   disp;
  logic [PS_W-1:0]       ps;
  logic [IDX_W-1:0]      idx;
  logic                  scan_step;
  logic [DIGITS-1:0]     lead_zero;
  logic [3:0]            bcd_p0;
  logic [DIGITS-1:0]     an_p0;
  logic [3:0]            bcd_p1;
  logic [DIGITS-1:0]     an_p1;
  logic                  conv_done_p1;

  assign bus.in_ready = !busy;
  assign accept       = bus.in_valid && !busy;

  bin2bcd_dd #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_dd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .bin     (bus.in_bin),
    .busy    (busy),
    .done    (commit),
    .bcd_out (conv_bcd)
  );

  // Display register only moves on commit, so the scan never shows a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp <= '0;
    end else if (commit) begin
      disp <= conv_bcd;
    end
  end

  assign scan_step = (ps == PS_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps  <= '0;
      idx <= '0;
    end else begin
      ps <= scan_step ? '0 : ps + 1'b1;
      if (scan_step) begin
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // lead_zero[i]: digits i..DIGITS-1 are all zero.
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run          = run && (disp[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end

  always_comb begin
    bcd_p0 = disp[4*int'(idx) +: 4];
    an_p0  = DIGITS'(1) << idx;
    if (bus.blank_lz && (idx != '0) && lead_zero[idx]) begin
      bcd_p0 = BLANK_CODE;
    end
  end

  // Output stage: registered digit code, enable and commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_p1       <= '0;
      an_p1        <= DIGITS'(1);
      conv_done_p1 <= 1'b0;
    end else begin
      bcd_p1       <= bcd_p0;
      an_p1        <= an_p0;
      conv_done_p1 <= commit;
    end
  end

  assign bus.bcd       = bcd_p1;
  assign bus.an        = an_p1;
  assign bus.conv_done = conv_done_p1;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver with a 4-cycle digit dwell.
module tb_bcd_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_scan_driver_if #(.BIN_W(14), .DIGITS(4)) bus ();

  bcd_scan_driver #(
    .DIGITS   (4),
    .BIN_W    (14),
    .SCAN_DIV (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [13:0] v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = v;
    for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.conv_done) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Collects one full scan; d packs digit 3..0 as {d3,d2,d1,d0}.
  task automatic read_display(output logic [15:0] d, output bit ok);
    logic [3:0] seen;
    seen = '0;
    d    = '0;
    for (int i = 0; i < 40 && seen != 4'hF; i++) begin
      @(negedge clk);
      case (bus.an)
        4'b0001: begin d[3:0]   = bus.bcd; seen[0] = 1'b1; end
        4'b0010: begin d[7:4]   = bus.bcd; seen[1] = 1'b1; end
        4'b0100: begin d[11:8]  = bus.bcd; seen[2] = 1'b1; end
        4'b1000: begin d[15:12] = bus.bcd; seen[3] = 1'b1; end
        default: ;
      endcase
    end
    ok = (seen == 4'hF);
  endtask

  task automatic test_reset;
    logic [3:0] exp_an;
    bus.in_valid = 1'b0;
    bus.in_bin   = '0;
    bus.blank_lz = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.an !== 4'b0001) begin errors++; $display("FAIL reset_an got %b exp 0001", bus.an); end
    checks++; if (bus.bcd !== 4'h0) begin errors++; $display("FAIL reset_bcd got %h exp 0", bus.bcd); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.conv_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.conv_done); end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_an = 4'(4'b0001 << (((k - 1) / 4) % 4));
      checks++;
      if (bus.an !== exp_an) begin
        errors++;
        $display("FAIL scan_step cycle %0d an got %b exp %b", k, bus.an, exp_an);
      end
    end
  endtask

  task automatic test_accept;
    int          ready_low;
    int          dones;
    bit          tear;
    bit          ok;
    logic [15:0] d;
    ready_low = 0;
    dones     = 0;
    tear      = 1'b0;
    bus.blank_lz = 1'b0;
    send(14'd1234);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dones == 0 && bus.bcd !== 4'h0) tear = 1'b1;
      if (!bus.in_ready) ready_low++;
      if (bus.conv_done) dones++;
    end
    checks++; if (ready_low != 14) begin errors++; $display("FAIL accept_ready_low got %0d exp 14", ready_low); end
    checks++; if (dones != 1) begin errors++; $display("FAIL accept_done_pulses got %0d exp 1", dones); end
    checks++; if (tear) begin errors++; $display("FAIL accept_no_tear got nonzero digit exp 0 before commit"); end
    read_display(d, ok);
    checks++; if (!ok) begin errors++; $display("FAIL accept_scan got incomplete scan exp all digits"); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL accept_1234 got %h exp 1234", d); end
  endtask

  task automatic test_clamp;
    logic [13:0] vals [3];
    logic [15:0] exps [3];
    logic [15:0] d;
    bit          ok;
    vals = '{14'd12000, 14'd1, 14'd9999};
    exps = '{16'h9999, 16'h0001, 16'h9999};
    bus.blank_lz = 1'b0;
    for (int t = 0; t < 3; t++) begin
      send(vals[t]);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL clamp_done value %0d got timeout exp pulse", vals[t]); end
      read_display(d, ok);
      checks++;
      if (!ok || d !== exps[t]) begin
        errors++;
        $display("FAIL clamp value %0d got %h exp %h", vals[t], d, exps[t]);
      end
    end
  endtask

  task automatic test_blanking;
    logic [13:0] vals   [4];
    logic        blanks [4];
    logic [15:0] exps   [4];
    logic [15:0] d;
    bit          ok;
    vals   = '{14'd7, 14'd0, 14'd0, 14'd1005};
    blanks = '{1'b1, 1'b1, 1'b0, 1'b1};
    exps   = '{16'hFFF7, 16'hFFF0, 16'h0000, 16'h1005};
    for (int t = 0; t < 4; t++) begin
      bus.blank_lz = blanks[t];
      send(vals[t]);
      wait_done(ok);
      read_display(d, ok);
      checks++;
      if (!ok || d !== exps[t]) begin
        errors++;
        $display("FAIL blank value %0d lz %0d got %h exp %h", vals[t], blanks[t], d, exps[t]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int          ready_hi;
    int          dones;
    int          samples;
    bit          bad42;
    bit          ok;
    int          di;
    logic [15:0] exp42;
    logic [15:0] d;
    ready_hi = 0;
    dones    = 0;
    samples  = 0;
    bad42    = 1'b0;
    exp42    = 16'h0042;
    bus.blank_lz = 1'b0;
    send(14'd42);
    bus.in_valid = 1'b1;
    bus.in_bin   = 14'd77;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.conv_done) dones++;
      if (bus.in_valid && bus.in_ready) ready_hi++;
      else if (bus.in_valid && !bus.in_ready && ready_hi > 0) bus.in_valid = 1'b0;
      if (dones == 1 && !bus.conv_done && !bus.in_ready) begin
        di = 0;
        case (bus.an)
          4'b0010: di = 1;
          4'b0100: di = 2;
          4'b1000: di = 3;
          default: di = 0;
        endcase
        samples++;
        if (bus.bcd !== exp42[4*di +: 4]) bad42 = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (ready_hi != 1) begin errors++; $display("FAIL b2b_idle_cycles got %0d exp 1", ready_hi); end
    checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 2", dones); end
    checks++; if (bad42 || samples == 0) begin errors++; $display("FAIL b2b_show_42 got bad=%0d samples=%0d exp 0042 shown", bad42, samples); end
    read_display(d, ok);
    checks++; if (!ok || d !== 16'h0077) begin errors++; $display("FAIL b2b_77 got %h exp 0077", d); end
  endtask

  task automatic test_reset_mid_conv;
    int          dones;
    bit          ok;
    logic [15:0] d;
    dones = 0;
    bus.blank_lz = 1'b0;
    send(14'd5555);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.an !== 4'b0001) begin errors++; $display("FAIL midrst_an got %b exp 0001", bus.an); end
    checks++; if (bus.bcd !== 4'h0) begin errors++; $display("FAIL midrst_bcd got %h exp 0", bus.bcd); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.conv_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", bus.conv_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.conv_done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", dones); end
    read_display(d, ok);
    checks++; if (!ok || d !== 16'h0000) begin errors++; $display("FAIL midrst_display got %h exp 0000", d); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_accept();
    test_clamp();
    test_blanking();
    test_back_to_back();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Upstream feeder for the BCD-to-7-segment decoder on the multiplexed display. It accepts a binary value over a valid/ready handshake and converts it to DIGITS BCD digits with a sequential double-dabble converter. It then time-multiplexes those digits onto one `bcd` bus with a one-hot digit enable. Blanked digits are driven as code 4'hF, which the decoder renders as all segments off.

## Interface
- `DIGITS`, 4: number of display digits; index 0 is the least significant digit.
- `BIN_W`, 14: width of the binary input.
- `SCAN_DIV`, 50000: clocks per digit dwell; must be ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset is asynchronous and active-low.
- `in_valid`  in  1: `in_bin` is presented.
- `in_ready`  out  1: block can accept a value.
- `in_bin`  in  BIN_W: unsigned value to display.
- `blank_lz`  in  1: enables leading-zero blanking; sampled live.
- `conv_done`  out  1: one-cycle pulse when a new value is committed to the display.
- `bcd`  out  4: digit code for the decoder.
- `an`  out  DIGITS: one-hot digit enable, active high.

## Operation
- FSM has two states:
  - IDLE: `in_ready`=1. On `in_valid && in_ready` the input is accepted and the FSM goes to CONV.
  - CONV: `in_ready`=0. It lasts exactly BIN_W cycles, then returns to IDLE.
- Clamp at accept: if `in_bin` ≥ 10^DIGITS, load 10^DIGITS−1 (all 9s) instead.
- Conversion is double-dabble:
  - Each CONV cycle, first add 3 to every BCD nibble ≥ 5, then shift the binary MSB into the BCD LSB.
  - Shift register width is BIN_W + 4·DIGITS.
- Commit: the last CONV edge writes the BCD result to the display register `disp` and pulses `conv_done`.
- `disp` never changes at any other time. The scan therefore shows the old value for the whole conversion, with no tearing.
- Scan:
  - Prescaler counts 0..SCAN_DIV−1 and wraps.
  - On wrap, digit index `idx` increments and wraps DIGITS−1 → 0.
  - `an` = 1<<`idx`; `bcd` = `disp[idx]`.
- Blanking: digit i > 0 is blanked (`bcd`=4'hF, `an` still asserted) if `blank_lz`=1 and digits i..DIGITS−1 of `disp` are all zero. Digit 0 is never blanked.
- Simultaneous events:
  - A scan step during CONV proceeds normally.
  - A commit coinciding with a scan step shows the new digit at the new index in the next cycle.
  - While `in_ready`=0, `in_valid` is ignored. The upstream must hold the value and it is taken on the first IDLE cycle.

## Timing
- Accept edge T. CONV covers edges T+1..T+BIN_W. Commit is at edge T+BIN_W.
- `conv_done`=1 during cycle T+BIN_W..T+BIN_W+1; `in_ready`=1 from the same cycle.
- Back-to-back throughput: one value per BIN_W+1 cycles.
- `bcd` and `an` are registered. They reflect `disp`/`idx` one cycle after either changes.
- Each digit dwells exactly SCAN_DIV cycles.
- Reset values:
  - state IDLE, `in_ready`=1, `conv_done`=0.
  - `disp`=0, `idx`=0, prescaler=0.
  - `an`=1 (digit 0), `bcd`=0.
- Reset asserted mid-conversion aborts the conversion. All outputs take their reset values immediately, so the display shows 0 and the in-flight value is lost.

## Structure
- Shared package holds:
  - `BLANK_CODE` = 4'hF.
  - FSM state type {IDLE, CONV}.
  - Clamp constant function 10^DIGITS−1.
- Sub-module `bin2bcd_dd` holds the sequential double-dabble datapath:
  - Inputs: `start`, `bin`. Outputs: `busy`, `done`, `bcd_out`. Owns the FSM and clamp.
- Top level holds the `disp` register, prescaler, index counter and blanking logic.

## Test plan
- Reset (SCAN_DIV=4 in all tests): `rst_n`=0 → `an`=0001, `bcd`=0, `in_ready`=1, `conv_done`=0. After release, `an` steps 0001→0010→0100→1000→0001, 4 cycles per step.
- Accept 1234: `in_ready` low exactly 14 cycles, single `conv_done` pulse. Scan then shows 4,3,2,1 on `an`=0001,0010,0100,1000. Digits stay 0 until commit.
- Accept 12000: displays 9,9,9,9 (clamp). Accept 9999: same result, no clamp path needed.
- Leading-zero blanking:
  - `blank_lz`=1, value 7 → `bcd`=7,F,F,F.
  - `blank_lz`=1, value 0 → `bcd`=0,F,F,F.
  - `blank_lz`=0, value 0 → 0,0,0,0.
  - `blank_lz`=1, value 1005 → 5,0,0,1.
- Handshake: drive 42, then hold `in_valid` with 77 during CONV. 77 is accepted on the first IDLE cycle only, and the display goes 42 then 77 with two `conv_done` pulses.
- Reset mid-CONV (value 5555, `rst_n` low at cycle 6): outputs return to reset values asynchronously. No `conv_done` occurs and the display reads 0000.
